soc_axi_initiator: RTL and testbench

//  Single-outstanding AXI4 initiator turning simple command/response requests into single-beat AXI4

---
 rtl/soc_axi_init_pkg.sv | 25 ++
 rtl/soc_axi_initiator.sv | 221 ++++++++++++++++++++++
 tb/tb_soc_axi_initiator.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_axi_init_pkg.sv
// Shared types and AXI encodings for the single-outstanding AXI4 initiator.
package soc_axi_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_RD_ADDR,
        ST_WR_RESP,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Up to two stray beats (one B, one R) can arrive in the same cycle.
    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/soc_axi_initiator.sv
// Single-outstanding AXI4 initiator: one command in, one single-beat AXI transfer, one response out.
// Optional response-wait timeout enabled by defining SOC_AXI_INIT_TIMEOUT_EN.
module soc_axi_initiator
    import soc_axi_init_pkg::*;
#(
    parameter int TAGW    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic            aclk,
    input  logic            rst,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [31:0]     cmd_addr,
    input  logic [31:0]     cmd_wdata,
    input  logic [3:0]      cmd_wstrb,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_err,
    output logic [7:0]      stale_cnt,

    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [TAGW-1:0] awid,
    output logic [7:0]      awlen,
    output logic [1:0]      awburst,
    output logic [2:0]      awsize,

    output logic            wvalid,
    input  logic            wready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,

    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    input  logic [TAGW-1:0] bid,

    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [TAGW-1:0] arid,
    output logic [7:0]      arlen,
    output logic [1:0]      arburst,
    output logic [2:0]      arsize,

    input  logic            rvalid,
    output logic            rready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic [TAGW-1:0] rid,
    input  logic            rlast
);

    state_t          state;
    state_t          state_next;
    logic [TAGW-1:0] id_cnt;
    logic [TAGW-1:0] id;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            aw_done;
    logic            w_done;
    logic            b_match;
    logic            r_match;
    logic            timed_out;
    logic            b_stale;
    logic            r_stale;

    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awid    = id;
    assign arid    = id;
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign awsize  = AXI_SIZE_4B;
    assign arsize  = AXI_SIZE_4B;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign bready  = 1'b1;
    assign rready  = 1'b1;

    // Anything not consumed as the matching response is a stray beat, whatever the state.
    assign b_stale = bvalid & ~b_match;
    assign r_stale = rvalid & ~r_match;

`ifdef SOC_AXI_INIT_TIMEOUT_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WR_RESP || state == ST_RD_DATA) begin
            wait_cnt <= wait_cnt + 32'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timed_out = (state == ST_WR_RESP || state == ST_RD_DATA) &&
                       (wait_cnt == 32'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        arvalid    = 1'b0;
        rsp_valid  = 1'b0;
        b_match    = 1'b0;
        r_match    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    state_next = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if ((aw_done || awready) && (w_done || wready)) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = ST_RD_DATA;
                end
            end
            ST_WR_RESP: begin
                b_match = bvalid && (bid == id);
                if (b_match || timed_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD_DATA: begin
                r_match = rvalid && (rid == id);
                if (r_match || timed_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command capture, AW/W handshake tracking, response capture and stray-beat counting.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            id_cnt    <= '0;
            id        <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            rsp_err   <= 1'b0;
            stale_cnt <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                id      <= id_cnt;
                id_cnt  <= id_cnt + 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_done <= 1'b1;
            end
            if (wvalid && wready) begin
                w_done <= 1'b1;
            end
            if (b_match) begin
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
                rsp_err   <= (bresp != AXI_RESP_OKAY);
            end else if (r_match) begin
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
                rsp_err   <= (rresp != AXI_RESP_OKAY) || !rlast;
            end else if (timed_out) begin
                rsp_rdata <= '0;
                rsp_resp  <= AXI_RESP_SLVERR;
                rsp_err   <= 1'b1;
            end
            stale_cnt <= sat_add8(stale_cnt, {1'b0, b_stale} + {1'b0, r_stale});
        end
    end

endmodule

// File: tb/tb_soc_axi_initiator.sv
// Randomized bench for soc_axi_initiator acting as the AXI slave, with a transaction-level reference model.
// Define SOC_AXI_INIT_TIMEOUT_EN to also exercise the response timeout (TIMEOUT=16).
module tb_soc_axi_initiator;

    localparam int TAGW = 16;
`ifdef SOC_AXI_INIT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            aclk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [31:0]     cmd_addr = '0;
    logic [31:0]     cmd_wdata = '0;
    logic [3:0]      cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_err;
    logic [7:0]      stale_cnt;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [31:0]     awaddr;
    logic [TAGW-1:0] awid;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic [2:0]      awsize;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [1:0]      bresp = '0;
    logic [TAGW-1:0] bid = '0;
    logic            arvalid;
    logic            arready = 1'b0;
    logic [31:0]     araddr;
    logic [TAGW-1:0] arid;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic [2:0]      arsize;
    logic            rvalid = 1'b0;
    logic            rready;
    logic [31:0]     rdata = '0;
    logic [1:0]      rresp = '0;
    logic [TAGW-1:0] rid = '0;
    logic            rlast = 1'b0;

    int              checks = 0;
    int              errors = 0;
    int              cyc_cnt = 0;
    int              m_stale = 0;
    logic [TAGW-1:0] m_id = '0;
    logic [TAGW-1:0] cur_id = '0;

    soc_axi_initiator #(.TAGW(TAGW), .TIMEOUT(TO)) dut (
        .aclk(aclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .stale_cnt(stale_cnt),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awburst(awburst), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arburst(arburst), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void add_stale(input int n);
        m_stale = (m_stale + n > 255) ? 255 : m_stale + n;
    endfunction

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws, output int acc);
        @(negedge aclk);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge aclk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        acc    = cyc_cnt;
        cur_id = m_id;
        m_id   = m_id + 1'b1;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_addr_phase(input int aw_dly, input int w_dly, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] ws);
        bit aw_d = 1'b0;
        bit w_d  = 1'b0;
        for (int c = 0; c < 40 && !(aw_d && w_d); c++) begin
            @(negedge aclk);
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            checks++;
            if (awvalid !== !aw_d || wvalid !== !w_d) begin
                errors++;
                $display("[TB] FAIL wr_valids: awvalid=%b wvalid=%b required %b %b",
                         awvalid, wvalid, !aw_d, !w_d);
            end
            if (awvalid === 1'b1 && awready) begin
                checks++;
                if ({awaddr, awid, awlen, awburst, awsize} !== {addr, cur_id, 8'd0, 2'b01, 3'b010}) begin
                    errors++;
                    $display("[TB] FAIL aw_payload: addr=%h id=%h len=%h burst=%b size=%b required %h %h 00 01 010",
                             awaddr, awid, awlen, awburst, awsize, addr, cur_id);
                end
                aw_d = 1'b1;
            end
            if (wvalid === 1'b1 && wready) begin
                checks++;
                if ({wdata, wstrb, wlast} !== {wd, ws, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL w_payload: data=%h strb=%h last=%b required %h %h 1",
                             wdata, wstrb, wlast, wd, ws);
                end
                w_d = 1'b1;
            end
        end
        checks++;
        if (!(aw_d && w_d)) begin
            errors++;
            $display("[TB] FAIL wr_handshake: aw_done=%b w_done=%b required 1 1", aw_d, w_d);
        end
    endtask

    task automatic b_phase(input int n_stale, input logic [1:0] bresp_v);
        @(negedge aclk);
        awready = 1'b0;
        wready  = 1'b0;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_after_hs: awvalid=%b wvalid=%b bready=%b required 0 0 1",
                     awvalid, wvalid, bready);
        end
        for (int k = 0; k < n_stale; k++) begin
            bvalid = 1'b1;
            bid    = cur_id + TAGW'(1 + $urandom_range(0, 50));
            bresp  = 2'($urandom);
            @(negedge aclk);
        end
        add_stale(n_stale);
        bvalid = 1'b1;
        bid    = cur_id;
        bresp  = bresp_v;
        @(negedge aclk);
        bvalid = 1'b0;
    endtask

    task automatic rd_addr_phase(input int ar_dly, input logic [31:0] addr, output int hs);
        bit done = 1'b0;
        hs = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge aclk);
            arready = (c >= ar_dly);
            checks++;
            if (arvalid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ar_valid: arvalid=%b required 1", arvalid);
            end
            if (arvalid === 1'b1 && arready) begin
                checks++;
                if ({araddr, arid, arlen, arburst, arsize} !== {addr, cur_id, 8'd0, 2'b01, 3'b010}) begin
                    errors++;
                    $display("[TB] FAIL ar_payload: addr=%h id=%h len=%h burst=%b size=%b required %h %h 00 01 010",
                             araddr, arid, arlen, arburst, arsize, addr, cur_id);
                end
                done = 1'b1;
                hs   = cyc_cnt + 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL ar_handshake: done=0 required 1");
        end
    endtask

    task automatic r_phase(input int n_stale, input logic [31:0] rd, input logic [1:0] rresp_v,
                           input logic rlast_v);
        @(negedge aclk);
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_after_hs: arvalid=%b rready=%b required 0 1", arvalid, rready);
        end
        for (int k = 0; k < n_stale; k++) begin
            rvalid = 1'b1;
            rid    = cur_id + TAGW'(1 + $urandom_range(0, 50));
            rdata  = $urandom;
            rresp  = 2'($urandom);
            rlast  = 1'b1;
            @(negedge aclk);
        end
        add_stale(n_stale);
        rvalid = 1'b1;
        rid    = cur_id;
        rdata  = rd;
        rresp  = rresp_v;
        rlast  = rlast_v;
        @(negedge aclk);
        rvalid = 1'b0;
    endtask

    task automatic wait_rsp(output int seen);
        for (int i = 0; i < TO + 40 && rsp_valid !== 1'b1; i++) @(negedge aclk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
        end
        seen = cyc_cnt;
    endtask

    task automatic consume_rsp(input logic [31:0] e_rdata, input logic [1:0] e_resp,
                               input logic e_err, input int hold);
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_err} !==
                {1'b1, 1'b0, e_rdata, e_resp, e_err}) begin
                errors++;
                $display("[TB] FAIL rsp_fields: valid=%b cmd_ready=%b rdata=%h resp=%b err=%b required 1 0 %h %b %b",
                         rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_err, e_rdata, e_resp, e_err);
            end
            checks++;
            if (stale_cnt !== 8'(m_stale)) begin
                errors++;
                $display("[TB] FAIL stale_cnt: got %0d required %0d", stale_cnt, m_stale);
            end
            if (h < hold) begin
                if ($urandom_range(0, 1) == 1) begin
                    bvalid = 1'b1;
                    bid    = TAGW'($urandom);
                    add_stale(1);
                end
                @(negedge aclk);
                bvalid = 1'b0;
            end
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                             input int aw_dly, input int w_dly, input int n_stale,
                             input logic [1:0] bresp_v, input int hold, output int lat);
        int acc;
        int seen;
        send_cmd(1'b1, addr, wd, ws, acc);
        wr_addr_phase(aw_dly, w_dly, addr, wd, ws);
        b_phase(n_stale, bresp_v);
        wait_rsp(seen);
        lat = seen - acc;
        consume_rsp(32'h0, bresp_v, bresp_v != 2'b00, hold);
    endtask

    task automatic run_read(input logic [31:0] addr, input int ar_dly, input int n_stale,
                            input logic [31:0] rd, input logic [1:0] rresp_v, input logic rlast_v,
                            input int hold, output int lat);
        int acc;
        int seen;
        int hs;
        send_cmd(1'b0, addr, $urandom, 4'($urandom), acc);
        rd_addr_phase(ar_dly, addr, hs);
        r_phase(n_stale, rd, rresp_v, rlast_v);
        wait_rsp(seen);
        lat = seen - acc;
        consume_rsp(rd, rresp_v, (rresp_v != 2'b00) || !rlast_v, hold);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if ({cmd_ready, awvalid, wvalid, arvalid, rsp_valid, rsp_err, bready, rready} !== 8'b0000_0011) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: cmd_ready/aw/w/ar/rsp_valid/err/bready/rready=%b required 00000011",
                     {cmd_ready, awvalid, wvalid, arvalid, rsp_valid, rsp_err, bready, rready});
        end
        checks++;
        if ({rsp_rdata, rsp_resp, stale_cnt} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: rdata=%h resp=%b stale=%0d required 0 0 0",
                     rsp_rdata, rsp_resp, stale_cnt);
        end
        rst     = 1'b0;
        m_id    = '0;
        m_stale = 0;
        @(negedge aclk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        int lat;
        run_write(32'h0, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 2'b00, 0, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL write_latency: got %0d cycles required 3", lat);
        end
    endtask

    task automatic test_read_basic();
        int lat;
        run_read(32'h8, 0, 0, 32'h1234_5678, 2'b00, 1'b1, 1, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("[TB] FAIL read_latency: got %0d cycles required 3", lat);
        end
    endtask

    task automatic test_aw_late();
        int lat;
        run_write({$urandom_range(0, 255), 2'b00}, $urandom, 4'($urandom), 3, 0, 0, 2'b00, 2, lat);
        checks++;
        if (lat != 6) begin
            errors++;
            $display("[TB] FAIL aw_late_latency: got %0d cycles required 6", lat);
        end
    endtask

    task automatic test_stale_id();
        int lat;
        run_write(32'h10, $urandom, 4'h3, 0, 0, 1, 2'b00, 1, lat);
        run_read(32'h14, 1, 1, $urandom, 2'b00, 1'b1, 0, lat);
    endtask

    task automatic test_read_errors();
        int lat;
        run_read(32'h20, 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b1, 0, lat);
        run_read(32'h24, 0, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 1, lat);
    endtask

    task automatic test_idle_stale();
        @(negedge aclk);
        bvalid = 1'b1;
        rvalid = 1'b1;
        bid    = TAGW'($urandom);
        rid    = TAGW'($urandom);
        @(negedge aclk);
        bvalid = 1'b0;
        rvalid = 1'b0;
        add_stale(2);
        @(negedge aclk);
        checks++;
        if (stale_cnt !== 8'(m_stale)) begin
            errors++;
            $display("[TB] FAIL idle_stale: got %0d required %0d", stale_cnt, m_stale);
        end
    endtask

    task automatic test_random();
        int lat;
        int dly_a;
        int dly_b;
        int ns;
        for (int i = 0; i < 24; i++) begin
            dly_a = $urandom_range(0, 3);
            dly_b = $urandom_range(0, 3);
            ns    = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                run_write({$urandom_range(0, 1023), 2'b00}, $urandom, 4'($urandom), dly_a, dly_b, ns,
                          2'($urandom), $urandom_range(0, 2), lat);
                checks++;
                if (lat != 3 + ((dly_a > dly_b) ? dly_a : dly_b) + ns) begin
                    errors++;
                    $display("[TB] FAIL rand_write_latency: got %0d required %0d", lat,
                             3 + ((dly_a > dly_b) ? dly_a : dly_b) + ns);
                end
            end else begin
                run_read({$urandom_range(0, 1023), 2'b00}, dly_a, ns, $urandom, 2'($urandom),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 2), lat);
                checks++;
                if (lat != 3 + dly_a + ns) begin
                    errors++;
                    $display("[TB] FAIL rand_read_latency: got %0d required %0d", lat, 3 + dly_a + ns);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int lat;
        logic [TAGW-1:0] old_id;
        send_cmd(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, acc);
        wr_addr_phase(0, 0, 32'h40, 32'h5555_AAAA, 4'hF);
        @(negedge aclk);
        awready = 1'b0;
        wready  = 1'b0;
        old_id  = cur_id;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, awvalid, wvalid, arvalid, rsp_valid, stale_cnt} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: cmd_ready=%b aw=%b w=%b ar=%b rsp_valid=%b stale=%0d required all 0",
                     cmd_ready, awvalid, wvalid, arvalid, rsp_valid, stale_cnt);
        end
        @(negedge aclk);
        rst     = 1'b0;
        m_id    = '0;
        m_stale = 0;
        bvalid  = 1'b1;
        bid     = old_id;
        bresp   = 2'b00;
        @(negedge aclk);
        bvalid = 1'b0;
        add_stale(1);
        checks++;
        if (stale_cnt !== 8'(m_stale)) begin
            errors++;
            $display("[TB] FAIL late_beat_stale: got %0d required %0d", stale_cnt, m_stale);
        end
        run_write(32'h44, 32'h0BAD_CAFE, 4'h5, 0, 1, 0, 2'b00, 0, lat);
    endtask

`ifdef SOC_AXI_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int acc;
        int hs;
        int seen;
        send_cmd(1'b0, 32'h80, 32'h0, 4'h0, acc);
        rd_addr_phase(0, 32'h80, hs);
        @(negedge aclk);
        arready = 1'b0;
        wait_rsp(seen);
        checks++;
        if (seen - hs != TO) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got %0d required %0d", seen - hs, TO);
        end
        consume_rsp(32'h0, 2'b10, 1'b1, 1);
        rvalid = 1'b1;
        rid    = cur_id;
        rdata  = 32'h1111_2222;
        rresp  = 2'b00;
        rlast  = 1'b1;
        @(negedge aclk);
        rvalid = 1'b0;
        add_stale(1);
        checks++;
        if (stale_cnt !== 8'(m_stale)) begin
            errors++;
            $display("[TB] FAIL timeout_late_stale: got %0d required %0d", stale_cnt, m_stale);
        end
    endtask
`endif

    task automatic test_saturation();
        for (int i = 0; i < 131; i++) begin
            @(negedge aclk);
            bvalid = 1'b1;
            rvalid = 1'b1;
            bid    = TAGW'($urandom);
            rid    = TAGW'($urandom);
            add_stale(2);
        end
        @(negedge aclk);
        bvalid = 1'b0;
        rvalid = 1'b0;
        checks++;
        if (stale_cnt !== 8'(m_stale) || stale_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL stale_saturate: got %0d required %0d", stale_cnt, m_stale);
        end
    endtask

    initial begin
        $display("[TB] soc_axi_initiator bench start (TIMEOUT=%0d)", TO);
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_late();
        test_stale_id();
        test_read_errors();
        test_idle_stale();
        test_random();
        test_reset_mid();
`ifdef SOC_AXI_INIT_TIMEOUT_EN
        test_timeout();
`endif
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
